lcd_cmd_arbiter: RTL and testbench
==================================

Name: lcd_cmd_arbiter

Overview:
Shares the character-LCD bus between two command/data requesters. Requester 0 is the IR-decode display path and requester 1 is the CPU/Avalon write path. The block arbitrates round-robin, then sequences each HD44780-style write: RS/data setup, EN pulse, hold, and execution wait. It sits between the requesters and the exported LCD conduit pins; the bus is write-only, so RW is always low.

Parameters:
T_SETUP, 2, cycles RS/data stable before EN rises (min 1)
T_EN, 12, cycles EN held high (min 1)
T_HOLD, 2, cycles RS/data held after EN falls (min 1)
T_EXEC, 2000, execution wait for normal commands/data (40 us @ 50 MHz)
T_LONG, 82000, execution wait for clear/home commands (1.64 ms @ 50 MHz)
T_PWRUP, 750000, power-up wait before init sequence (used only with LCD_INIT_SEQ_EN)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has a transfer
req0_data  in  9  {rs, data[7:0]} for requester 0
req0_ready  out  1  requester 0 transfer accepted this cycle when valid
req1_valid  in  1  requester 1 has a transfer
req1_data  in  9  {rs, data[7:0]} for requester 1
req1_ready  out  1  requester 1 accept
busy  out  1  a transfer is in progress (state != IDLE)
init_done  out  1  LCD initialised; requests are serviced
lcd_data  out  8  LCD DB[7:0]
lcd_rw  out  1  constant 0
lcd_en  out  1  LCD enable strobe
lcd_rs  out  1  register select
lcd_on  out  1  LCD power
lcd_blon  out  1  backlight

Behaviour:
- One clock, clk_clk. reset_reset is asynchronous, active-high, and takes effect immediately.
- Reset values:
  - lcd_en=0, lcd_rs=0, lcd_data=0x00, lcd_rw=0.
  - lcd_on=1, lcd_blon=1.
  - busy=0.
  - req*_ready=0 while reset is asserted.
- All lcd_* outputs are registered.
- States: IDLE, SETUP, PULSE, HOLD, EXEC.
- Down-counter width is $clog2 of the largest T_* parameter. Each state loads T_x-1 on entry and exits when the counter is 0.
- req*_ready is combinational and high only in IDLE with init_done=1, and only for the granted requester.
- Accept occurs on valid & ready. The accepted word is latched into lcd_rs/lcd_data, and the FSM moves to SETUP on the next cycle.
- Arbitration:
  - A last_grant register resets to 1, so req0 wins the first contention.
  - With one requester valid, that requester is granted.
  - With both valid, the requester != last_grant is granted.
  - last_grant updates on accept only.
- Sequencing after accept:
  - SETUP: T_SETUP cycles, lcd_en=0.
  - PULSE: T_EN cycles, lcd_en=1.
  - HOLD: T_HOLD cycles, lcd_en=0; rs/data unchanged.
  - EXEC: T_LONG cycles if rs=0 and data in {0x01,0x02,0x03}, else T_EXEC cycles.
  - Then return to IDLE.
- busy is high for exactly T_SETUP+T_EN+T_HOLD+exec cycles, starting the cycle after accept.
- lcd_rs/lcd_data keep their last value in IDLE; they are not returned to 0.
- Valid without ready: the request waits. Requesters must hold valid and data stable until accepted. Data changes before accept are not sampled.
- Back-to-back: an accept is possible in the first IDLE cycle after EXEC. The minimum spacing between accepts is 1+T_SETUP+T_EN+T_HOLD+T_EXEC cycles.
- Reset mid-transfer:
  - The in-flight word is dropped and not replayed.
  - lcd_en goes to 0 asynchronously.
  - The FSM returns to IDLE (or INIT_WAIT with the feature enabled).

Optional Feature:
LCD_INIT_SEQ_EN

- Defined:
  - After reset, the block waits T_PWRUP cycles in INIT_WAIT.
  - It then issues internal writes rs=0 of 0x38, 0x0C, 0x01, 0x06 in that order, using the normal SETUP/PULSE/HOLD/EXEC sequence (0x01 uses T_LONG).
  - init_done=0 and both ready=0 until the last EXEC completes, then init_done=1.
  - busy=1 during the init writes, not during INIT_WAIT.
- Undefined: there are no init states, init_done is constant 1, and the block is in IDLE immediately after reset.

Test Plan:
All tests override T_SETUP=2, T_EN=3, T_HOLD=1, T_EXEC=5, T_LONG=20, T_PWRUP=10.

- Single data write: req0 {1,0x41} -> req0_ready high same cycle; next cycle lcd_rs=1, lcd_data=0x41; lcd_en high cycles 3-5 after accept; busy high 11 cycles; lcd_rw=0 throughout.
- Long command: req1 {0,0x01} -> EN pulse 3 cycles; busy high 26 cycles. Repeat with {0,0x80} -> busy 11 cycles.
- Contention: both valid continuously with req0=0x100+n, req1=0x1AA -> grants alternate 0,1,0,1 starting with req0; accepts spaced exactly 12 cycles apart.
- Reset during PULSE: assert reset_reset while lcd_en=1 -> lcd_en=0 before the next clk_clk edge, busy=0, ready=0. After release with both valid -> req0 granted first.
- Held request: req1 valid while req0's transfer is in EXEC -> req1_ready stays 0 until IDLE, then accepted with the data value present at the accept cycle.
- With LCD_INIT_SEQ_EN: reset release -> 10 idle cycles, then 4 EN pulses carrying 0x38, 0x0C, 0x01, 0x06 with rs=0. A req0 held valid meanwhile is accepted only after init_done rises.

Source files
------------

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter
// Shares a write-only HD44780-style character-LCD bus between two requesters.
// Requester 0 is the IR-decode display path and requester 1 is the CPU/Avalon path.
// Requests are granted round-robin. Each accepted word is then driven onto the bus
// with this timing: RS/data setup, an EN pulse, a hold time, and an execution wait.
//
// Optional feature: define LCD_INIT_SEQ_EN to add a power-up wait. The wait is
// followed by the internal init writes 0x38, 0x0C, 0x01 and 0x06. No request is
// served until those writes finish.
//
// Ports:
//   clk_clk, reset_reset          clock, asynchronous active-high reset
//   req0_valid/req0_data/ready    requester 0 handshake, data = {rs, db[7:0]}
//   req1_valid/req1_data/ready    requester 1 handshake, data = {rs, db[7:0]}
//   busy                          a transfer (or an init write) is in progress
//   init_done                     the LCD is initialised and requests are served
//   lcd_data/rw/en/rs/on/blon     exported LCD conduit (all registered)
module lcd_cmd_arbiter #(
   parameter int unsigned T_SETUP = 2,
   parameter int unsigned T_EN    = 12,
   parameter int unsigned T_HOLD  = 2,
   parameter int unsigned T_EXEC  = 2000,
   parameter int unsigned T_LONG  = 82000,
   parameter int unsigned T_PWRUP = 750000
) (
   input  logic       clk_clk,
   input  logic       reset_reset,
   input  logic       req0_valid,
   input  logic [8:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [8:0] req1_data,
   output logic       req1_ready,
   output logic       busy,
   output logic       init_done,
   output logic [7:0] lcd_data,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic       lcd_rs,
   output logic       lcd_on,
   output logic       lcd_blon
);

   // The shared down-counter is sized to hold the largest interval.
   localparam int unsigned T_MAX_A = (T_SETUP > T_EN)     ? T_SETUP : T_EN;
   localparam int unsigned T_MAX_B = (T_HOLD > T_EXEC)    ? T_HOLD  : T_EXEC;
   localparam int unsigned T_MAX_C = (T_LONG > T_PWRUP)   ? T_LONG  : T_PWRUP;
   localparam int unsigned T_MAX_D = (T_MAX_A > T_MAX_B)  ? T_MAX_A : T_MAX_B;
   localparam int unsigned T_MAX   = (T_MAX_C > T_MAX_D)  ? T_MAX_C : T_MAX_D;
   localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_EXEC,
      S_INIT_WAIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last_grant;
   logic             grant;
   logic             idle_rdy;
   logic             accept;
   logic [8:0]       acc_word;
   logic             exec_long;

`ifdef LCD_INIT_SEQ_EN
   localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);

   logic [1:0] init_idx;

   // Fixed init program: 8-bit bus with 2 lines, display on, clear, entry mode.
   function automatic logic [7:0] init_word(input logic [1:0] idx);
      case (idx)
         2'd0:    init_word = 8'h38;
         2'd1:    init_word = 8'h0C;
         2'd2:    init_word = 8'h01;
         default: init_word = 8'h06;
      endcase
   endfunction
`else
   assign init_done = 1'b1;
`endif

   // Round-robin grant. With contention the requester that did not win last time is chosen.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
      idle_rdy   = (state == S_IDLE) && init_done && !reset_reset;
      req0_ready = idle_rdy && !grant;
      req1_ready = idle_rdy && grant;
      accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
      acc_word   = grant ? req1_data : req0_data;
   end

   // Clear (0x01) and return-home (0x02/0x03) commands need the long execution wait.
   assign exec_long = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02) ||
                                  (lcd_data == 8'h03));

   // Bus sequencer. Every timed state loads interval-1 on entry and leaves when the count reaches 0.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
`ifdef LCD_INIT_SEQ_EN
         state     <= S_INIT_WAIT;
         cnt       <= LD_PWRUP;
         init_done <= 1'b0;
         init_idx  <= 2'd0;
`else
         state     <= S_IDLE;
         cnt       <= '0;
`endif
         last_grant <= 1'b1;
         busy       <= 1'b0;
         lcd_en     <= 1'b0;
         lcd_rs     <= 1'b0;
         lcd_data   <= 8'h00;
         lcd_rw     <= 1'b0;
         lcd_on     <= 1'b1;
         lcd_blon   <= 1'b1;
      end else begin
         lcd_rw   <= 1'b0;
         lcd_on   <= 1'b1;
         lcd_blon <= 1'b1;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lcd_rs     <= acc_word[8];
                  lcd_data   <= acc_word[7:0];
                  last_grant <= grant;
                  busy       <= 1'b1;
                  cnt        <= LD_SETUP;
                  state      <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt == '0) begin
                  lcd_en <= 1'b1;
                  cnt    <= LD_EN;
                  state  <= S_PULSE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_PULSE: begin
               if (cnt == '0) begin
                  lcd_en <= 1'b0;
                  cnt    <= LD_HOLD;
                  state  <= S_HOLD;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  cnt   <= exec_long ? LD_LONG : LD_EXEC;
                  state <= S_EXEC;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_EXEC: begin
               if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
                  // Go straight on to the next init word. Only the last one ends in IDLE.
                  if (!init_done && (init_idx != 2'd3)) begin
                     init_idx <= init_idx + 2'd1;
                     lcd_rs   <= 1'b0;
                     lcd_data <= init_word(init_idx + 2'd1);
                     cnt      <= LD_SETUP;
                     state    <= S_SETUP;
                  end else begin
                     init_done <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end
`else
                  busy  <= 1'b0;
                  state <= S_IDLE;
`endif
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
`ifdef LCD_INIT_SEQ_EN
            S_INIT_WAIT: begin
               if (cnt == '0) begin
                  lcd_rs   <= 1'b0;
                  lcd_data <= init_word(2'd0);
                  busy     <= 1'b1;
                  cnt      <= LD_SETUP;
                  state    <= S_SETUP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
`endif
            default: begin
               lcd_en <= 1'b0;
               busy   <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb_lcd_cmd_arbiter
// Scoreboard bench for lcd_cmd_arbiter. The bench pushes the expected words with the
// expected grant source and busy length. A bus monitor pops an entry on each EN rising
// edge and compares the bus against it.
module tb_lcd_cmd_arbiter;

   localparam int T_SETUP = 2;
   localparam int T_EN    = 3;
   localparam int T_HOLD  = 1;
   localparam int T_EXEC  = 5;
   localparam int T_LONG  = 20;
   localparam int T_PWRUP = 10;
   localparam int XFER    = T_SETUP + T_EN + T_HOLD;
   localparam int BUSY_N  = XFER + T_EXEC;
   localparam int BUSY_L  = XFER + T_LONG;
   localparam int SPACING = 1 + BUSY_N;
   localparam int LIMIT   = 500;

   logic       clk_clk = 1'b0;
   logic       reset_reset;
   logic       req0_valid, req1_valid;
   logic [8:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic       busy, init_done;
   logic [7:0] lcd_data;
   logic       lcd_rw, lcd_en, lcd_rs, lcd_on, lcd_blon;

   lcd_cmd_arbiter #(
      .T_SETUP(T_SETUP), .T_EN(T_EN), .T_HOLD(T_HOLD),
      .T_EXEC(T_EXEC), .T_LONG(T_LONG), .T_PWRUP(T_PWRUP)
   ) dut (
      .clk_clk    (clk_clk),
      .reset_reset(reset_reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .busy       (busy),
      .init_done  (init_done),
      .lcd_data   (lcd_data),
      .lcd_rw     (lcd_rw),
      .lcd_en     (lcd_en),
      .lcd_rs     (lcd_rs),
      .lcd_on     (lcd_on),
      .lcd_blon   (lcd_blon)
   );

   always #5 clk_clk = ~clk_clk;

   typedef struct {
      logic       src;
      logic [8:0] word;
      int         busy_len;
      bit         is_init;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   always @(posedge clk_clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int busy_for(input logic [8:0] w);
      if (!w[8] && (w[7:0] >= 8'h01) && (w[7:0] <= 8'h03)) return BUSY_L;
      return BUSY_N;
   endfunction

   task automatic push(input logic src, input logic [8:0] w);
      exp_q.push_back('{src, w, busy_for(w), 1'b0});
   endtask

   // Bus monitor: tracks accepts and EN edges, and checks busy length.
   logic prev_en = 1'b0, prev_busy = 1'b0, acc_src = 1'b0;
   int   busy_cnt = 0, en_rise = 0, acc_last = 0, acc_prev = 0;
   exp_t cur;
   bit   have_cur = 1'b0;

   always @(negedge clk_clk) begin
      if (reset_reset) begin
         prev_en  = 1'b0;
         prev_busy = 1'b0;
         busy_cnt = 0;
         have_cur = 1'b0;
      end else begin
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            acc_prev = acc_last;
            acc_last = cyc;
            acc_src  = req1_valid && req1_ready;
         end
         if (lcd_en && !prev_en) begin
            check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               cur      = exp_q.pop_front();
               have_cur = 1'b1;
               check_eq("bus_word", {23'd0, lcd_rs, lcd_data}, {23'd0, cur.word});
               check_eq("rw_low", 32'(lcd_rw), 0);
               if (!cur.is_init) begin
                  check_eq("grant_src", 32'(acc_src), 32'(cur.src));
                  check_eq("en_latency", cyc - acc_last, T_SETUP + 1);
               end
            end
            en_rise = cyc;
         end
         if (!lcd_en && prev_en) check_eq("en_width", cyc - en_rise, T_EN);
         if (busy) begin
            busy_cnt++;
         end else if (prev_busy) begin
            check_eq("busy_len", busy_cnt, have_cur ? cur.busy_len : -1);
            busy_cnt = 0;
         end
         prev_en   = lcd_en;
         prev_busy = busy;
      end
   end

   task automatic wait_accept(input logic src);
      bit got = 1'b0;
      for (int k = 0; k < LIMIT; k++) begin
         @(negedge clk_clk);
         if (src ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
            got = 1'b1;
            break;
         end
      end
      check_eq("accept_seen", 32'(got), 1);
   endtask

   task automatic send(input logic src, input logic [8:0] w);
      @(posedge clk_clk);
      #1;
      if (src) begin req1_data = w; req1_valid = 1'b1; end
      else     begin req0_data = w; req0_valid = 1'b1; end
      wait_accept(src);
      @(posedge clk_clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check_eq("latch", {23'd0, lcd_rs, lcd_data}, {23'd0, w});
   endtask

   task automatic wait_idle();
      for (int k = 0; k < LIMIT; k++) begin
         @(negedge clk_clk);
         if (!busy) break;
      end
      check_eq("idle_reached", 32'(busy), 0);
   endtask

   // Both requesters stay valid for n accepts. Optionally req0 advances its data after each accept.
   task automatic contend(input int n, input bit inc0);
      @(posedge clk_clk);
      #1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         bit got = 1'b0;
         bit src = 1'b0;
         for (int k = 0; k < LIMIT; k++) begin
            @(negedge clk_clk);
            if (req0_ready || req1_ready) begin
               got = 1'b1;
               src = req1_ready;
               break;
            end
         end
         check_eq("contend_accept", 32'(got), 1);
         @(posedge clk_clk);
         #1;
         if (i > 0) check_eq("spacing", acc_last - acc_prev, SPACING);
         if (!src && inc0) req0_data = req0_data + 9'd1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic post_reset();
`ifdef LCD_INIT_SEQ_EN
      bit got = 1'b0;
      int early = 0;
      exp_q.push_back('{1'b0, 9'h038, 0, 1'b1});
      exp_q.push_back('{1'b0, 9'h00C, 0, 1'b1});
      exp_q.push_back('{1'b0, 9'h001, 0, 1'b1});
      exp_q.push_back('{1'b0, 9'h006, 3 * BUSY_N + BUSY_L, 1'b1});
      req0_data  = 9'h1EE;
      req0_valid = 1'b1;
      for (int k = 0; k < LIMIT; k++) begin
         @(negedge clk_clk);
         if (init_done) begin
            got = 1'b1;
            break;
         end
         if (req0_ready || req1_ready) early++;
      end
      req0_valid = 1'b0;
      check_eq("init_done", 32'(got), 1);
      check_eq("rdy_before_init", early, 0);
`else
      @(negedge clk_clk);
      check_eq("init_done", 32'(init_done), 1);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_reset = 1'b1;
      req0_valid  = 1'b1;
      req0_data   = 9'h141;
      req1_valid  = 1'b1;
      req1_data   = 9'h1AA;
      repeat (3) @(negedge clk_clk);
      check_eq("rst_en",   32'(lcd_en), 0);
      check_eq("rst_rs",   32'(lcd_rs), 0);
      check_eq("rst_data", 32'(lcd_data), 0);
      check_eq("rst_rw",   32'(lcd_rw), 0);
      check_eq("rst_on",   32'(lcd_on), 1);
      check_eq("rst_blon", 32'(lcd_blon), 1);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_rdy0", 32'(req0_ready), 0);
      check_eq("rst_rdy1", 32'(req1_ready), 0);
      req0_valid  = 1'b0;
      req1_valid  = 1'b0;
      reset_reset = 1'b0;
      post_reset();

      // Single writes, including the boundaries of the long-exec decode.
      push(1'b0, 9'h141); send(1'b0, 9'h141); wait_idle();
      push(1'b1, 9'h001); send(1'b1, 9'h001); wait_idle();
      push(1'b1, 9'h080); send(1'b1, 9'h080); wait_idle();
      push(1'b0, 9'h003); send(1'b0, 9'h003); wait_idle();
      push(1'b1, 9'h004); send(1'b1, 9'h004); wait_idle();
      push(1'b1, 9'h101); send(1'b1, 9'h101); wait_idle();

      // Contention: the grant alternates starting with req0, and accepts are 12 cycles apart.
      req0_data = 9'h100;
      req1_data = 9'h1AA;
      push(1'b0, 9'h100); push(1'b1, 9'h1AA);
      push(1'b0, 9'h101); push(1'b1, 9'h1AA);
      contend(4, 1'b1);
      wait_idle();

      // Held request: req1 arrives while req0 is in EXEC and its data changes before accept.
      push(1'b0, 9'h122);
      send(1'b0, 9'h122);
      repeat (6) @(posedge clk_clk);
      #1;
      req1_data  = 9'h1BB;
      req1_valid = 1'b1;
      @(negedge clk_clk);
      check_eq("held_rdy", 32'(req1_ready), 0);
      check_eq("held_busy", 32'(busy), 1);
      @(posedge clk_clk);
      #1;
      req1_data = 9'h1CC;
      push(1'b1, 9'h1CC);
      wait_accept(1'b1);
      @(posedge clk_clk);
      #1;
      req1_valid = 1'b0;
      check_eq("held_latch", {23'd0, lcd_rs, lcd_data}, 32'h1CC);
      check_eq("held_spacing", acc_last - acc_prev, SPACING);
      wait_idle();

      // Reset during the EN pulse drops the word, and req0 then wins the first contention.
      push(1'b0, 9'h155);
      send(1'b0, 9'h155);
      for (int k = 0; k < LIMIT; k++) begin
         @(negedge clk_clk);
         if (lcd_en) break;
      end
      check_eq("pulse_seen", 32'(lcd_en), 1);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #2;
      reset_reset = 1'b1;
      #1;
      check_eq("mid_rst_en",   32'(lcd_en), 0);
      check_eq("mid_rst_busy", 32'(busy), 0);
      check_eq("mid_rst_rdy0", 32'(req0_ready), 0);
      check_eq("mid_rst_rdy1", 32'(req1_ready), 0);
      repeat (2) @(negedge clk_clk);
      req0_valid  = 1'b0;
      req1_valid  = 1'b0;
      reset_reset = 1'b0;
      post_reset();
      req0_data = 9'h033;
      req1_data = 9'h1AB;
      push(1'b0, 9'h033);
      push(1'b1, 9'h1AB);
      contend(2, 1'b0);
      wait_idle();

      repeat (3) @(negedge clk_clk);
      check_eq("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
